// File: rtl/adc_seq_pkg.sv
// Shared types and defaults for the OrangeCrab ADC mux sequencer.
// States, the mux park code and default timing parameters.
package adc_seq_pkg;

    typedef enum logic [1:0] {
        PARK   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [3:0] MUX_PARK = 4'd0;

    localparam int SETTLE_DEFAULT      = 480;
    localparam int SAMPLE_LOG2_DEFAULT = 10;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Synchronous active-high reset clears both flops.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/adc_mux_sequencer.sv
// Channel select, settle and first-order sigma-delta conversion
// for the 74HC4067 analog front end; mux parks on Y0 when idle.
module adc_mux_sequencer
    import adc_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_DEFAULT,
    parameter int SAMPLE_LOG2   = SAMPLE_LOG2_DEFAULT
) (
    input  logic                   ref_clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [3:0]             req_chan,
    output logic                   req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [3:0]             rsp_chan,
    output logic [SAMPLE_LOG2:0]   rsp_count,
    output logic                   busy,
    input  logic                   adc_sense_hi,
    output logic [3:0]             adc_mux,
    output logic                   adc_ctrl1,
    output logic                   adc_ctrl0
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CW = SAMPLE_LOG2 + 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [3:0]             chan_q, chan_d;
    logic [3:0]             mux_q, mux_d;
    logic                   ctrl0_q, ctrl0_d;
    logic [SW-1:0]          settle_q, settle_d;
    logic [SAMPLE_LOG2-1:0] smp_q, smp_d;
    logic [CW-1:0]          ones_q, ones_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             rchan_q, rchan_d;
    logic                   rvalid_q, rvalid_d;
    logic                   sense_s;
    logic [CW-1:0]          ones_inc;

    sync_2ff u_sense_sync (
        .clk_i (ref_clk),
        .rst_i (rst),
        .d_i   (adc_sense_hi),
        .q_o   (sense_s)
    );

    // Count includes the current cycle's sample, so the last cycle lands too.
    assign ones_inc = ones_q + CW'(sense_s);

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        mux_d    = mux_q;
        ctrl0_d  = ctrl0_q;
        settle_d = settle_q;
        smp_d    = smp_q;
        ones_d   = ones_q;
        cnt_d    = cnt_q;
        rchan_d  = rchan_q;
        rvalid_d = rvalid_q;
        unique case (state_q)
            PARK: begin
                mux_d   = MUX_PARK;
                ctrl0_d = 1'b0;
                if (req_valid) begin
                    chan_d   = req_chan;
                    mux_d    = req_chan;
                    settle_d = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                settle_d = settle_q + 1'b1;
                ctrl0_d  = 1'b0;
                if (settle_q == SETTLE_LAST) begin
                    smp_d   = '0;
                    ones_d  = '0;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                ctrl0_d = ~sense_s;
                ones_d  = ones_inc;
                smp_d   = smp_q + 1'b1;
                if (&smp_q) begin
                    cnt_d    = ones_inc;
                    rchan_d  = chan_q;
                    rvalid_d = 1'b1;
                    mux_d    = MUX_PARK;
                    ctrl0_d  = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = PARK;
                end
            end
            default: state_d = PARK;
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q  <= PARK;
            chan_q   <= '0;
            mux_q    <= MUX_PARK;
            ctrl0_q  <= 1'b0;
            settle_q <= '0;
            smp_q    <= '0;
            ones_q   <= '0;
            cnt_q    <= '0;
            rchan_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            mux_q    <= mux_d;
            ctrl0_q  <= ctrl0_d;
            settle_q <= settle_d;
            smp_q    <= smp_d;
            ones_q   <= ones_d;
            cnt_q    <= cnt_d;
            rchan_q  <= rchan_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign req_ready = (state_q == PARK);
    assign busy      = (state_q != PARK);
    assign rsp_valid = rvalid_q;
    assign rsp_chan  = rchan_q;
    assign rsp_count = cnt_q;
    assign adc_mux   = mux_q;
    assign adc_ctrl0 = ctrl0_q;
    assign adc_ctrl1 = 1'b0;

endmodule

// File: tb/tb_adc_mux_sequencer.sv
// Bench for adc_mux_sequencer: default and minimum-size instances,
// checked against an input-history model of the sigma-delta count.
module tb_adc_mux_sequencer;

    localparam int S  = 480;
    localparam int L  = 10;
    localparam int S2 = 1;
    localparam int L2 = 4;

    logic ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_chan = '0;
    logic        rsp_ready = 1'b0;
    logic        adc_sense_hi = 1'b0;
    logic        req_ready, rsp_valid, busy, adc_ctrl1, adc_ctrl0;
    logic [3:0]  rsp_chan, adc_mux;
    logic [L:0]  rsp_count;

    logic        s_req_valid = 1'b0;
    logic [3:0]  s_req_chan = '0;
    logic        s_rsp_ready = 1'b1;
    logic        s_req_ready, s_rsp_valid, s_busy, s_ctrl1, s_ctrl0;
    logic [3:0]  s_rsp_chan, s_mux;
    logic [L2:0] s_rsp_count;

    adc_mux_sequencer #(.SETTLE_CYCLES(S), .SAMPLE_LOG2(L)) dut (
        .ref_clk(ref_clk), .rst(rst),
        .req_valid(req_valid), .req_chan(req_chan), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_chan(rsp_chan), .rsp_count(rsp_count), .busy(busy),
        .adc_sense_hi(adc_sense_hi), .adc_mux(adc_mux),
        .adc_ctrl1(adc_ctrl1), .adc_ctrl0(adc_ctrl0)
    );

    adc_mux_sequencer #(.SETTLE_CYCLES(S2), .SAMPLE_LOG2(L2)) dut_s (
        .ref_clk(ref_clk), .rst(rst),
        .req_valid(s_req_valid), .req_chan(s_req_chan), .req_ready(s_req_ready),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
        .rsp_chan(s_rsp_chan), .rsp_count(s_rsp_count), .busy(s_busy),
        .adc_sense_hi(adc_sense_hi), .adc_mux(s_mux),
        .adc_ctrl1(s_ctrl1), .adc_ctrl0(s_ctrl0)
    );

    int checks = 0;
    int errors = 0;
    int mode = 0;
    int edge_n = 0;
    bit hist[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // hist[e] is the comparator level seen at clock edge e.
    task automatic step();
        hist.push_back(adc_sense_hi);
        @(posedge ref_clk);
        #1;
        edge_n = hist.size() - 1;
        case (mode)
            0: adc_sense_hi = 1'b0;
            1: adc_sense_hi = 1'b1;
            2: adc_sense_hi = ~adc_sense_hi;
            default: adc_sense_hi = 1'($urandom & 1);
        endcase
    endtask

    // Sample edges T+s+1..T+s+2^l see the input two edges earlier.
    function automatic int exp_count(int t, int s, int l);
        int n = 0;
        for (int e = t + s - 1; e <= t + s + (1 << l) - 2; e++)
            n += int'(hist[e]);
        return n;
    endfunction

    task automatic do_conv(input logic [3:0] ch, input int md,
                           input int hold, output int cnt);
        int t;
        int ex;
        mode = md;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_chan = ch;
        step();
        t = edge_n;
        req_valid = 1'b0;
        req_chan = 4'($urandom);
        chk("accept_ready", req_ready, 0);
        chk("accept_busy", busy, 1);
        chk("accept_mux", adc_mux, ch);
        for (int k = 1; k < S + (1 << L); k++) begin
            step();
            chk("mux_hold", adc_mux, ch);
            chk("rsp_early", rsp_valid, 0);
            chk("ctrl1_low", adc_ctrl1, 0);
            if (k <= S)
                chk("ctrl0_settle", adc_ctrl0, 0);
            else
                chk("ctrl0_fb", adc_ctrl0, 32'(!hist[edge_n - 2]));
        end
        step();
        ex = exp_count(t, S, L);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_chan", rsp_chan, ch);
        chk("rsp_count", rsp_count, ex);
        chk("mux_parked", adc_mux, 0);
        chk("ctrl0_parked", adc_ctrl0, 0);
        chk("done_busy", busy, 1);
        chk("done_ready", req_ready, 0);
        cnt = int'(rsp_count);
        for (int h = 0; h < hold; h++) begin
            req_valid = (h == hold / 2);
            req_chan = 4'd3;
            step();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_count", rsp_count, ex);
            chk("bp_chan", rsp_chan, ch);
            chk("bp_ready", req_ready, 0);
            chk("bp_mux", adc_mux, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hs_valid", rsp_valid, 0);
        chk("hs_ready", req_ready, 1);
        chk("hs_busy", busy, 0);
        chk("hs_count_kept", rsp_count, ex);
        chk("hs_chan_kept", rsp_chan, ch);
        step();
        chk("park_busy", busy, 0);
        chk("park_mux", adc_mux, 0);
    endtask

    initial begin
        int c;
        int t;
        logic [3:0] ch;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_mux", adc_mux, 0);
            chk("rst_valid", rsp_valid, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle_mux", adc_mux, 0);
            chk("idle_ctrl1", adc_ctrl1, 0);
            chk("idle_ctrl0", adc_ctrl0, 0);
            chk("idle_ready", req_ready, 1);
            chk("idle_valid", rsp_valid, 0);
            chk("idle_busy", busy, 0);
        end

        do_conv(4'd5, 1, 0, c);
        chk("full_scale", c, 1024);
        do_conv(4'd15, 0, 0, c);
        chk("zero_scale", c, 0);
        do_conv(4'd6, 2, 0, c);
        chk("mid_scale", 32'(c >= 511 && c <= 513), 1);
        do_conv(4'd11, 3, 50, c);
        do_conv(4'd3, 3, 0, c);

        mode = 3;
        req_valid = 1'b1;
        req_chan = 4'd9;
        step();
        req_valid = 1'b0;
        for (int k = 1; k < 700; k++) step();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_mux", adc_mux, 0);
        chk("mrst_ctrl0", adc_ctrl0, 0);
        chk("mrst_valid", rsp_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", req_ready, 1);
        chk("mrst_count", rsp_count, 0);
        chk("mrst_chan", rsp_chan, 0);
        do_conv(4'd2, 3, 0, c);

        rst = 1'b1;
        req_valid = 1'b1;
        req_chan = 4'd7;
        step();
        rst = 1'b0;
        req_valid = 1'b0;
        chk("rstreq_busy", busy, 0);
        step();
        chk("rstreq_busy2", busy, 0);
        chk("rstreq_mux", adc_mux, 0);

        mode = 1;
        step();
        step();
        s_req_valid = 1'b1;
        s_req_chan = 4'hA;
        step();
        s_req_valid = 1'b0;
        chk("s_mux", s_mux, 4'hA);
        for (int k = 1; k < S2 + (1 << L2); k++) begin
            step();
            chk("s_early", s_rsp_valid, 0);
        end
        step();
        chk("s_valid", s_rsp_valid, 1);
        chk("s_count", s_rsp_count, 16);
        chk("s_chan", s_rsp_chan, 4'hA);
        step();
        chk("s_hs", s_rsp_valid, 0);
        chk("s_idle", s_busy, 0);

        mode = 3;
        for (int r = 0; r < 8; r++) begin
            ch = 4'($urandom);
            s_req_valid = 1'b1;
            s_req_chan = ch;
            step();
            t = edge_n;
            s_req_valid = 1'b0;
            for (int k = 0; k < S2 + (1 << L2); k++) step();
            chk("sr_valid", s_rsp_valid, 1);
            chk("sr_chan", s_rsp_chan, ch);
            chk("sr_count", s_rsp_count, exp_count(t, S2, L2));
            step();
            chk("sr_park", s_req_ready, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
